// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundle of the fetch stage's redirect, instruction-memory and
// decode-side signals.
//
// Handshake semantics (both channels):
//   - imem_req/imem_ack: the fetch stage raises imem_req with imem_addr and holds
//     both unchanged until the edge at which imem_ack=1. imem_ack may be high in
//     the very cycle imem_req rises. The transfer happens on that edge, and
//     imem_data is valid only while imem_ack=1.
//   - out_valid/out_ready: the head entry (out_instr, out_pc) transfers on any
//     edge with out_valid=1 and out_ready=1. out_instr/out_pc are don't-care while
//     out_valid=0.
//
// Modports:
//   master - the fetch stage itself (drives requests and the decode channel)
//   slave  - the environment (CPU redirect logic, instruction memory, decode)
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_data;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          out_ready;
  logic [CW-1:0] count;
  logic [1:0]    fsm_state;  // debug view of the fetch FSM

  modport master (
    input  redirect, redirect_pc, imem_ack, imem_data, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, count, fsm_state
  );

  modport slave (
    output redirect, redirect_pc, imem_ack, imem_data, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, count, fsm_state
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage in front of decode.
//
// Generates sequential word-aligned fetch addresses, issues them to instruction
// memory with at most one request outstanding, and buffers returned words with
// their PCs in a DEPTH-entry FIFO presented to decode. A redirect flushes the
// FIFO, discards any in-flight response and restarts fetch at redirect_pc.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - fetch_queue_if.master: redirect/redirect_pc, imem_req/addr/ack/data,
//           out_valid/instr/pc/ready, count (entries held), fsm_state (debug)
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W    = (CW+1)'(DEPTH);
  localparam logic [CW:0] DEPTH_M1_W = (CW+1)'(DEPTH - 1);

  // IDLE: no request. WAIT: live request outstanding.
  // DISCARD: request outstanding whose response must be thrown away.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];

  logic          pop, push;
  logic [31:0]   target_pc;
  logic [CW:0]   occ_after_pop;
  logic          room_idle, room_wait;

  assign target_pc = bus.redirect_pc & ~32'h3;

  assign pop  = (count_q != '0) & bus.out_ready;
  assign push = (state_q == ST_WAIT) & bus.imem_ack & ~bus.redirect;

  // Occupancy once this cycle's pop is taken. A new request is only issued if
  // its response is guaranteed a slot, so the FIFO can never overflow.
  assign occ_after_pop = {1'b0, count_q} - (CW+1)'(pop);
  assign room_idle     = occ_after_pop < DEPTH_W;     // nothing being pushed now
  assign room_wait     = occ_after_pop < DEPTH_M1_W;  // one push lands this edge

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.redirect) begin
          addr_d     = target_pc;
          fetch_pc_d = target_pc + 32'd4;
          state_d    = ST_WAIT;
        end else if (room_idle) begin
          addr_d     = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.imem_ack) begin
          if (bus.redirect) begin
            // Response dropped; the redirected fetch goes out back-to-back.
            addr_d     = target_pc;
            fetch_pc_d = target_pc + 32'd4;
          end else if (room_wait) begin
            addr_d     = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (bus.redirect) begin
          // The outstanding request cannot be withdrawn: hold it, and remember
          // the new PC for when its stale response has been swallowed.
          fetch_pc_d = target_pc;
          state_d    = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (bus.redirect) fetch_pc_d = target_pc;
        if (bus.imem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  // FIFO control. A redirect flushes at the same edge; a pop in that cycle has
  // already been seen by decode, so it is simply overridden here.
  always_ff @(posedge clk) begin
    if (reset || bus.redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_instr[wr_ptr_q] <= bus.imem_data;
      mem_pc[wr_ptr_q]    <= addr_q;
    end
  end

  assign bus.imem_req  = (state_q != ST_IDLE);
  assign bus.imem_addr = addr_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = mem_instr[rd_ptr_q];
  assign bus.out_pc    = mem_pc[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue.
//
// The reference is a transaction-level view: decode must see the current PC
// stream (RESET_PC or the aligned redirect target, +4 each) with
// instr = pc ^ KEY, restarting on every redirect and reset. A memory response
// is live only if no redirect edge fell while its request was visible.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] KEY      = 32'hA5A50000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_pops = 0;
  logic [63:0] exp_q[$];      // {instr, pc} expected in the FIFO, head first
  logic [31:0] exp_fetch;     // next address of the live PC stream
  logic        cur_stale;     // outstanding request has seen a redirect
  logic        pend;          // request visible and unacked at the last edge
  logic [31:0] pend_addr;
  logic        after_reset;
  logic        model_on = 1'b0;

  // memory model
  logic        mem_busy;
  int          wait_left;
  int          lat_min, lat_max;
  logic [31:0] slow_addr;     // address that always gets 3 wait cycles

  // driver intent for the next edge
  logic        drv_reset, drv_redirect, drv_ready;
  logic [31:0] drv_rpc;

  // samples taken mid-cycle
  logic        s_req, s_valid, s_ack;
  logic [31:0] s_addr, s_pc, s_instr;
  int          s_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: sample and compare at the negedge, drive inputs, answer as
  // memory, then advance the reference across the coming posedge.
  task automatic step();
    logic        pop;
    logic [31:0] data_w;
    @(negedge clk);
    cyc++;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.out_valid;
    s_pc    = bus.out_pc;
    s_instr = bus.out_instr;
    s_count = 32'(bus.count);

    if (model_on) begin
      chk("count", 32'(s_count), 32'(exp_q.size()));
      chk("out_valid", 32'(s_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_pc", s_pc, exp_q[0][31:0]);
        chk("out_instr", s_instr, exp_q[0][63:32]);
      end
      if (after_reset) begin
        chk("req_after_reset", 32'(s_req), 32'd0);
        chk("addr_after_reset", s_addr, 32'd0);
      end
      if (pend) begin
        chk("req_held", 32'(s_req), 32'd1);
        chk("addr_stable", s_addr, pend_addr);
      end
    end

    reset           = drv_reset;
    bus.redirect    = drv_redirect;
    bus.redirect_pc = drv_rpc;
    bus.out_ready   = drv_ready;

    s_ack  = 1'b0;
    data_w = $urandom();
    if (s_req === 1'b1) begin
      if (!mem_busy) begin
        mem_busy  = 1'b1;
        wait_left = (s_addr == slow_addr) ? 3 : int'($urandom_range(lat_max, lat_min));
      end
      if (wait_left == 0) begin
        s_ack    = 1'b1;
        data_w   = s_addr ^ KEY;
        mem_busy = 1'b0;
      end else begin
        wait_left--;
      end
    end
    bus.imem_ack  = s_ack;
    bus.imem_data = data_w;

    after_reset = drv_reset;
    if (drv_reset) begin
      exp_q.delete();
      exp_fetch = RESET_PC;
      cur_stale = 1'b0;
      pend      = 1'b0;
      mem_busy  = 1'b0;
      model_on  = 1'b1;
    end else if (model_on) begin
      pop = (exp_q.size() != 0) && drv_ready;
      if (pop) begin
        void'(exp_q.pop_front());
        n_pops++;
      end
      if (s_req && s_ack) begin
        if (!cur_stale && !drv_redirect) begin
          chk("fetch_addr", s_addr, exp_fetch);
          n_checks++;
          if (exp_q.size() >= DEPTH) begin
            n_errors++;
            $display("FAIL overflow: push into %0d entries (cycle %0d)", exp_q.size(), cyc);
          end
          exp_q.push_back({exp_fetch ^ KEY, exp_fetch});
          exp_fetch = exp_fetch + 32'd4;
        end
        cur_stale = 1'b0;
      end else if (s_req && drv_redirect) begin
        cur_stale = 1'b1;
      end
      if (drv_redirect) begin
        exp_q.delete();
        exp_fetch = drv_rpc & ~32'h3;
      end
      pend      = s_req && !s_ack;
      pend_addr = s_addr;
    end
  endtask

  task automatic do_reset();
    drv_reset = 1'b1;
    drv_redirect = 1'b0;
    step();
    drv_reset = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    do begin
      step();
      n++;
    end while (!s_valid && n < max);
    n_checks++;
    if (!s_valid) begin
      n_errors++;
      $display("FAIL %s: out_valid never rose within %0d cycles", name, max);
    end
  endtask

  task automatic wait_req_addr(input string name, input logic [31:0] addr, input int max);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(s_req && s_addr == addr) && n < max);
    n_checks++;
    if (!(s_req && s_addr == addr)) begin
      n_errors++;
      $display("FAIL %s: request for %h not seen within %0d cycles", name, addr, max);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          first_req, first_val, n_val, acks, got, last_j, pops0;
    logic [31:0] pcs [5];
    logic        found;

    reset = 1'b1;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.out_ready = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_data = 32'h0;
    drv_reset = 1'b1; drv_redirect = 1'b0; drv_ready = 1'b1; drv_rpc = 32'h0;
    lat_min = 0; lat_max = 0; slow_addr = 32'h1;
    mem_busy = 1'b0; wait_left = 0;
    exp_fetch = RESET_PC; cur_stale = 1'b0; pend = 1'b0; pend_addr = 32'h0;
    after_reset = 1'b0;

    // Zero-wait stream: first request one cycle after reset, data one later.
    step();
    do_reset();
    first_req = -1; first_val = -1; n_val = 0; got = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_req && first_req < 0) first_req = i;
      if (s_valid && first_val < 0) first_val = i;
      if (s_valid) begin
        n_val++;
        if (got < 3) begin pcs[got] = s_pc; got++; end
      end
    end
    chk("first_req_cycle", 32'(first_req), 32'd1);
    chk("first_valid_cycle", 32'(first_val), 32'd2);
    chk("stream_gapless", 32'(n_val), 32'd10);
    chk("stream_pc0", pcs[0], 32'h0);
    chk("stream_pc1", pcs[1], 32'h4);
    chk("stream_pc2", pcs[2], 32'h8);

    // Backpressure: fill to DEPTH, then drain in order with no gaps.
    drv_ready = 1'b0;
    do_reset();
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_req && s_ack) acks++;
    end
    chk("bp_count_full", 32'(s_count), 32'd4);
    chk("bp_req_low", 32'(s_req), 32'd0);
    chk("bp_acks", 32'(acks), 32'd4);
    drv_ready = 1'b1;
    got = 0; last_j = -1;
    for (int j = 0; j < 12 && got < 5; j++) begin
      step();
      if (j == 1) chk("bp_req_reassert", 32'(s_req), 32'd1);
      if (s_valid) begin pcs[got] = s_pc; got++; last_j = j; end
    end
    for (int k = 0; k < 5; k++) chk("bp_order", pcs[k], 32'(k * 4));
    chk("bp_gapless", 32'(last_j), 32'd4);

    // Redirect while the request for 0x10 waits 3 cycles.
    slow_addr = 32'h10;
    do_reset();
    wait_req_addr("slow_req", 32'h10, 20);
    drv_redirect = 1'b1; drv_rpc = 32'h100;
    step();
    drv_redirect = 1'b0; slow_addr = 32'h1;
    chk("slow_addr_held", s_addr, 32'h10);
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      step();
      if (s_req && s_addr != 32'h10) found = 1'b1;
    end
    chk("redir_next_addr", s_addr, 32'h100);
    wait_valid("redir_valid", 10);
    chk("redir_out_pc", s_pc, 32'h100);
    chk("redir_out_instr", s_instr, 32'h100 ^ KEY);

    // Redirect coincident with an ack and a pop.
    do_reset();
    wait_req_addr("pre_coincide", 32'h1C, 20);
    drv_redirect = 1'b1; drv_rpc = 32'h200;
    step();
    drv_redirect = 1'b0;
    chk("coin_addr", s_addr, 32'h20);
    chk("coin_ack", 32'(s_ack), 32'd1);
    chk("coin_pop", 32'(s_valid), 32'd1);
    step();
    chk("coin_count0", 32'(s_count), 32'd0);
    chk("coin_valid0", 32'(s_valid), 32'd0);
    chk("coin_new_addr", s_addr, 32'h200);
    step();
    chk("coin_valid1", 32'(s_valid), 32'd1);
    chk("coin_out_pc", s_pc, 32'h200);

    // Alignment and wrap.
    drv_redirect = 1'b1; drv_rpc = 32'h103;
    step();
    drv_redirect = 1'b0;
    wait_valid("align_valid", 10);
    chk("align_pc", s_pc, 32'h100);
    drv_redirect = 1'b1; drv_rpc = 32'hFFFFFFFC;
    step();
    drv_redirect = 1'b0;
    wait_valid("wrap_valid0", 10);
    chk("wrap_pc0", s_pc, 32'hFFFFFFFC);
    wait_valid("wrap_valid1", 10);
    chk("wrap_pc1", s_pc, 32'h0);

    // Reset with three entries held and a request outstanding.
    lat_min = 2; lat_max = 2; drv_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (s_count == 3 && s_req && !s_ack) found = 1'b1;
    end
    chk("midreset_setup", 32'(found), 32'd1);
    do_reset();
    step();
    chk("midreset_valid", 32'(s_valid), 32'd0);
    chk("midreset_req", 32'(s_req), 32'd0);
    chk("midreset_count", 32'(s_count), 32'd0);
    drv_ready = 1'b1;
    wait_valid("midreset_restart", 20);
    chk("midreset_pc", s_pc, RESET_PC);
    chk("midreset_instr", s_instr, RESET_PC ^ KEY);

    // Randomized traffic against the reference.
    lat_min = 0; lat_max = 3;
    pops0 = n_pops;
    for (int i = 0; i < 3000; i++) begin
      drv_ready    = (i % 200 < 15) ? 1'b0 : ($urandom_range(3, 0) != 0);
      drv_redirect = ($urandom_range(19, 0) == 0);
      drv_reset    = ($urandom_range(499, 0) == 0);
      case ($urandom_range(2, 0))
        0:       drv_rpc = $urandom_range(1023, 0);
        1:       drv_rpc = 32'hFFFFFFF0 | $urandom_range(15, 0);
        default: drv_rpc = $urandom();
      endcase
      step();
    end
    drv_reset = 1'b0; drv_redirect = 1'b0;
    chk("random_progress", 32'((n_pops - pops0) > 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
